// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory port arbiter: FSM states,
// bus owner identifiers and the timeout counter width.
package mem_port_arbiter_pkg;

    localparam int TIMEOUT_W = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t BUS_IF  = 2'd1;
    localparam arb_state_t BUS_MEM = 2'd2;
    localparam arb_state_t DONE    = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Bus wait counter: cleared outside a bus transaction, counts bus cycles,
// and flags the cycle in which the TIMEOUT-th bus cycle completes.
module bus_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of bus cycles already spent, so the
    // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
    assign expired = enable && (count_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and the
// MEM stage, runs a request/ack transaction per access, and drives stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    arb_state_t        state_q,     state_d;
    logic              last_mem_q,  last_mem_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              bus_err_q,   bus_err_d;

    logic              mem_pend;
    logic              in_bus;
    logic              cur_owner;
    logic              owner_live;
    logic              tmo_expired;
    logic [DATA_W-1:0] captured;

    assign mem_pend   = mem_rd | mem_wr;
    assign in_bus     = (state_q == BUS_IF) || (state_q == BUS_MEM);
    assign cur_owner  = (state_q == BUS_MEM) ? OWN_MEM : OWN_IF;
    assign owner_live = (cur_owner == OWN_MEM) ? mem_pend : if_req;
    assign captured   = bus_ack ? bus_rdata : '0;

    bus_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_bus),
        .enable (in_bus),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        last_mem_d  = last_mem_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = bus_err_q;

        case (state_q)
            IDLE: begin
                // MEM normally wins, but IF gets the slot right after a MEM grant.
                if (mem_pend && !(last_mem_q && if_req)) begin
                    state_d     = BUS_MEM;
                    last_mem_d  = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_wr;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (if_req) begin
                    state_d    = BUS_IF;
                    last_mem_d = 1'b0;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr;
                end
            end
            BUS_IF, BUS_MEM: begin
                if (bus_ack || tmo_expired) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!bus_ack) begin
                        bus_err_d = 1'b1;
                    end
                    // A requester that has withdrawn gets neither data nor a pulse.
                    if (owner_live) begin
                        if (cur_owner == OWN_MEM) begin
                            mem_ready_d = 1'b1;
                            if (!bus_we_q) begin
                                mem_rdata_d = captured;
                            end
                        end else begin
                            if_ready_d = 1'b1;
                            if_rdata_d = captured;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_mem_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_mem_q  <= last_mem_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign bus_err   = bus_err_q;

    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = mem_pend & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              stall_if;
    logic              stall_mem;
    logic              bus_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic seen;
        do_reset();
        total++;
        if ({bus_req, bus_we, if_ready, mem_ready, bus_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus_req, bus_we, if_ready, mem_ready, bus_err});
        end
        total++;
        if (bus_addr !== '0 || bus_wdata !== '0) begin
            bad++;
            $display("FAIL reset_bus: got addr=%h wdata=%h want 0", bus_addr, bus_wdata);
        end
        total++;
        if (if_rdata !== '0 || mem_rdata !== '0) begin
            bad++;
            $display("FAIL reset_rdata: got if=%h mem=%h want 0", if_rdata, mem_rdata);
        end
        mem_rd    = 1'b1;
        mem_addr  = 32'h1001_0004;
        mem_wdata = 32'h0000_0055;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h1001_0004) begin
            bad++;
            $display("FAIL reset_pre_grant: got req=%b addr=%h want 1 10010004", bus_req, bus_addr);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus_req, bus_we, mem_ready, if_ready} !== 4'b0 || bus_addr !== '0) begin
            bad++;
            $display("FAIL reset_async: got req=%b we=%b rdy=%b%b addr=%h want all 0",
                     bus_req, bus_we, mem_ready, if_ready, bus_addr);
        end
        mem_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | mem_ready | if_ready | bus_req;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_pulse: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_if_fetch();
        if_req  = 1'b1;
        if_addr = 32'h0040_0000;
        #1;
        total++;
        if (stall_if !== 1'b1) begin
            bad++;
            $display("FAIL fetch_stall_c0: got %b want 1", stall_if);
        end
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h0040_0000 || stall_if !== 1'b1) begin
            bad++;
            $display("FAIL fetch_c1: got req=%b we=%b addr=%h stall=%b want 1 0 00400000 1",
                     bus_req, bus_we, bus_addr, stall_if);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h8C08_0004;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h8C08_0004 || stall_if !== 1'b0 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL fetch_c2: got rdy=%b data=%h stall=%b req=%b want 1 8c080004 0 0",
                     if_ready, if_rdata, stall_if, bus_req);
        end
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if (if_ready !== 1'b0) begin
            bad++;
            $display("FAIL fetch_pulse_len: got %b want 0", if_ready);
        end
    endtask

    task automatic test_load();
        mem_rd   = 1'b1;
        mem_addr = 32'h1001_0008;
        #1;
        total++;
        if (stall_mem !== 1'b1) begin
            bad++;
            $display("FAIL load_stall_c0: got %b want 1", stall_mem);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            total++;
            if (bus_req !== 1'b1 || stall_mem !== 1'b1 || bus_we !== 1'b0 || mem_ready !== 1'b0) begin
                bad++;
                $display("FAIL load_wait_c%0d: got req=%b stall=%b we=%b rdy=%b want 1 1 0 0",
                         c, bus_req, stall_mem, bus_we, mem_ready);
            end
            if (c == 4) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'h0000_002A;
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h0000_002A || stall_mem !== 1'b0) begin
            bad++;
            $display("FAIL load_c5: got rdy=%b data=%h stall=%b want 1 0000002a 0",
                     mem_ready, mem_rdata, stall_mem);
        end
        mem_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        mem_wr    = 1'b1;
        mem_addr  = 32'h1001_0000;
        mem_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            total++;
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h1001_0000) begin
                bad++;
                $display("FAIL store_c%0d: got req=%b we=%b wdata=%h addr=%h want 1 1 deadbeef 10010000",
                         c, bus_req, bus_we, bus_wdata, bus_addr);
            end
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h0000_002A) begin
            bad++;
            $display("FAIL store_done: got rdy=%b rdata=%h want 1 0000002a", mem_ready, mem_rdata);
        end
        mem_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h0040_0010;
        mem_rd   = 1'b1;
        mem_addr = 32'h1001_0020;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h1001_0020 || bus_we !== 1'b0) begin
            bad++;
            $display("FAIL fair_first_mem: got req=%b addr=%h we=%b want 1 10010020 0", bus_req, bus_addr, bus_we);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0011;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (mem_ready !== 1'b1 || if_ready !== 1'b0 || mem_rdata !== 32'h0000_0011) begin
            bad++;
            $display("FAIL fair_mem_done: got mrdy=%b irdy=%b data=%h want 1 0 00000011", mem_ready, if_ready, mem_rdata);
        end
        mem_rd    = 1'b0;
        mem_wr    = 1'b1;
        mem_addr  = 32'h1001_0024;
        mem_wdata = 32'h0000_0077;
        repeat (2) @(negedge clk);
        total++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0040_0010 || bus_we !== 1'b0) begin
            bad++;
            $display("FAIL fair_if_second: got req=%b addr=%h we=%b want 1 00400010 0", bus_req, bus_addr, bus_we);
        end
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0022;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (if_ready !== 1'b1 || mem_ready !== 1'b0 || if_rdata !== 32'h0000_0022) begin
            bad++;
            $display("FAIL fair_if_done: got irdy=%b mrdy=%b data=%h want 1 0 00000022", if_ready, mem_ready, if_rdata);
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h1001_0024 || bus_wdata !== 32'h0000_0077) begin
            bad++;
            $display("FAIL fair_mem_third: got req=%b we=%b addr=%h wdata=%h want 1 1 10010024 00000077",
                     bus_req, bus_we, bus_addr, bus_wdata);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (mem_ready !== 1'b1) begin
            bad++;
            $display("FAIL fair_store_done: got %b want 1", mem_ready);
        end
        mem_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic seen;
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h0040_0020;
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL tmo_prefetch: got rdy=%b data=%h want 1 12345678", if_ready, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0040_0024;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            total++;
            if (bus_req !== 1'b1 || bus_err !== 1'b0 || if_ready !== 1'b0) begin
                bad++;
                $display("FAIL tmo_wait_c%0d: got req=%b err=%b rdy=%b want 1 0 0", c, bus_req, bus_err, if_ready);
            end
        end
        @(negedge clk);
        total++;
        if (if_ready !== 1'b1 || if_rdata !== '0 || bus_err !== 1'b1 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL tmo_done: got rdy=%b data=%h err=%b req=%b want 1 0 1 0",
                     if_ready, if_rdata, bus_err, bus_req);
        end
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus_err !== 1'b1 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL tmo_sticky: got err=%b req=%b want 1 0", bus_err, bus_req);
        end
        if_req  = 1'b1;
        if_addr = 32'h0040_0028;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1) begin
            bad++;
            $display("FAIL flush_grant: got %b want 1", bus_req);
        end
        if_req = 1'b0;
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hAAAA_5555;
        seen      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus_ack = 1'b0;
            seen    = seen | if_ready;
        end
        total++;
        if (seen !== 1'b0 || if_rdata !== '0) begin
            bad++;
            $display("FAIL flush_no_pulse: got rdy_seen=%b data=%h want 0 0", seen, if_rdata);
        end
    endtask

    task automatic test_random();
        logic              m_last_mem;
        logic              m_err;
        logic [DATA_W-1:0] m_if_rdata;
        logic [DATA_W-1:0] m_mem_rdata;
        logic              pend_if, pend_mem, in_bus, cur_mem, timed, ok;
        logic [DATA_W-1:0] rd;
        int                sel, kind, k, nbus, gcount, cyc, gap;

        do_reset();
        m_last_mem  = 1'b0;
        m_err       = 1'b0;
        m_if_rdata  = '0;
        m_mem_rdata = '0;
        cur_mem     = 1'b0;
        k           = 0;
        rd          = '0;
        nbus        = 0;
        gcount      = 0;

        for (int s = 0; s < 40; s++) begin
            sel      = int'($urandom_range(0, 3));
            kind     = int'($urandom_range(0, 2));
            pend_if  = (sel != 1);
            pend_mem = (sel != 0);
            if_req    = pend_if;
            if_addr   = $urandom & 32'hFFFF_FFFC;
            mem_rd    = pend_mem && (kind != 1);
            mem_wr    = pend_mem && (kind != 0);
            mem_addr  = $urandom & 32'hFFFF_FFFC;
            mem_wdata = $urandom;
            in_bus    = 1'b0;
            cyc       = 0;

            while ((pend_if || pend_mem) && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (in_bus) gcount++;

                if (if_ready === 1'b1 || mem_ready === 1'b1) begin
                    total++;
                    if (!in_bus || mem_ready !== cur_mem || if_ready !== !cur_mem) begin
                        bad++;
                        $display("FAIL rnd_ready_owner s=%0d: got irdy=%b mrdy=%b want mem=%b", s, if_ready, mem_ready, cur_mem);
                    end
                    gap   = 1 + ((k < TIMEOUT) ? k : TIMEOUT - 1);
                    timed = (k >= TIMEOUT);
                    m_err = m_err | timed;
                    total++;
                    if (gcount != gap || bus_err !== m_err) begin
                        bad++;
                        $display("FAIL rnd_latency s=%0d: got gap=%0d err=%b want %0d %b", s, gcount, bus_err, gap, m_err);
                    end
                    if (cur_mem) begin
                        if (!mem_wr) m_mem_rdata = timed ? '0 : rd;
                        total++;
                        if (mem_rdata !== m_mem_rdata) begin
                            bad++;
                            $display("FAIL rnd_mem_rdata s=%0d: got %h want %h", s, mem_rdata, m_mem_rdata);
                        end
                        pend_mem = 1'b0;
                        mem_rd   = 1'b0;
                        mem_wr   = 1'b0;
                    end else begin
                        m_if_rdata = timed ? '0 : rd;
                        total++;
                        if (if_rdata !== m_if_rdata) begin
                            bad++;
                            $display("FAIL rnd_if_rdata s=%0d: got %h want %h", s, if_rdata, m_if_rdata);
                        end
                        pend_if = 1'b0;
                        if_req  = 1'b0;
                    end
                    in_bus = 1'b0;
                end

                // A fresh bus_req marks a grant; the model picks who should own it.
                if (!in_bus && bus_req === 1'b1) begin
                    cur_mem = pend_mem && !(m_last_mem && pend_if);
                    if (cur_mem)
                        ok = (bus_addr === mem_addr) && (bus_we === mem_wr) && (!mem_wr || bus_wdata === mem_wdata);
                    else
                        ok = (bus_addr === if_addr) && (bus_we === 1'b0);
                    total++;
                    if (!ok) begin
                        bad++;
                        $display("FAIL rnd_grant s=%0d: got addr=%h we=%b wdata=%h want mem=%b", s, bus_addr, bus_we, bus_wdata, cur_mem);
                    end
                    m_last_mem = cur_mem;
                    in_bus     = 1'b1;
                    gcount     = 0;
                    nbus       = 0;
                    k          = (s == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 5));
                    rd         = $urandom;
                end

                if (bus_req === 1'b1) begin
                    bus_ack   = (nbus == k);
                    bus_rdata = rd;
                    nbus++;
                end else begin
                    bus_ack   = 1'($urandom_range(0, 1));
                    bus_rdata = $urandom;
                end
            end

            total++;
            if (pend_if || pend_mem) begin
                bad++;
                $display("FAIL rnd_bound s=%0d: got pending if=%b mem=%b want none", s, pend_if, pend_mem);
                if_req = 1'b0;
                mem_rd = 1'b0;
                mem_wr = 1'b0;
            end
            bus_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_load();
        test_store();
        test_fairness();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
